// File: rtl/life_engine.sv
// life_engine: computes one Game of Life generation per accepted start pulse.
// Each output word is built from a 3x3 window of neighbouring words fetched
// from the current-generation buffer, then written to the next-generation
// buffer; a swap pulse follows the final write.
module life_engine #(
  parameter int WORD_SIZE     = 32,
  parameter int LOG_MAX_ADDR  = 11,
  parameter int ROWS          = 32,
  parameter int WORDS_PER_ROW = 2,
  parameter int READ_LATENCY  = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  output logic [LOG_MAX_ADDR-1:0] logic_addr_r_out,
  input  logic [WORD_SIZE-1:0]    logic_data_r_in,
  output logic [LOG_MAX_ADDR-1:0] logic_addr_w_out,
  output logic [WORD_SIZE-1:0]    logic_data_w_out,
  output logic                    logic_wr_en_out,
  output logic                    swap_out,
  output logic                    busy_out
);

  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WW      = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam int CNT_MAX = (READ_LATENCY > 9) ? READ_LATENCY : 9;
  localparam int CW      = $clog2(CNT_MAX);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, SWAP} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [RW-1:0]           row_q, row_d;
  logic [WW-1:0]           word_q, word_d;
  logic [LOG_MAX_ADDR-1:0] addr_r_q, addr_r_d;
  logic [LOG_MAX_ADDR-1:0] addr_w_q, addr_w_d;
  logic [WORD_SIZE-1:0]    data_w_q, data_w_d;
  logic                    wr_en_q, wr_en_d;
  logic                    swap_q, swap_d;
  logic                    busy_q, busy_d;
  logic [READ_LATENCY-1:0] pv_q, pv_d;
  logic [3:0]              pidx_q [READ_LATENCY];
  logic [3:0]              pidx_d [READ_LATENCY];
  logic [WORD_SIZE-1:0]    win_q [9];
  logic [WORD_SIZE-1:0]    win_d [9];
  logic [9*WORD_SIZE-1:0]  win_flat;
  logic [WORD_SIZE-1:0]    next_word;

  // Address of window slot k around (r,w), wrapping rows and words toroidally.
  function automatic logic [LOG_MAX_ADDR-1:0] nbr_addr(input int r, input int w, input int k);
    int rr;
    int ww;
    rr = r + k / 3 - 1;
    ww = w + k % 3 - 1;
    if (rr < 0) rr = ROWS - 1;
    else if (rr >= ROWS) rr = 0;
    if (ww < 0) ww = WORDS_PER_ROW - 1;
    else if (ww >= WORDS_PER_ROW) ww = 0;
    return LOG_MAX_ADDR'(rr * WORDS_PER_ROW + ww);
  endfunction

  // Rule applied to every bit of the centre word; edge bits borrow from the
  // adjacent words of the same window row.
  function automatic logic [WORD_SIZE-1:0] life_rule(input logic [9*WORD_SIZE-1:0] win);
    logic [WORD_SIZE+1:0] ext [3];
    logic [WORD_SIZE-1:0] lw, mw, rw;
    logic [WORD_SIZE-1:0] res;
    logic [3:0]           n;
    for (int j = 0; j < 3; j++) begin
      lw     = win[(3*j)*WORD_SIZE     +: WORD_SIZE];
      mw     = win[(3*j + 1)*WORD_SIZE +: WORD_SIZE];
      rw     = win[(3*j + 2)*WORD_SIZE +: WORD_SIZE];
      ext[j] = {rw[0], mw, lw[WORD_SIZE-1]};
    end
    for (int i = 0; i < WORD_SIZE; i++) begin
      n = 4'd0;
      for (int j = 0; j < 3; j++)
        for (int d = 0; d < 3; d++)
          if (!(j == 1 && d == 1)) n = n + {3'b000, ext[j][i+d]};
      res[i] = (n == 4'd3) | (ext[1][i+1] & (n == 4'd2));
    end
    return res;
  endfunction

  // Delay the fetch index by the read latency and drop returned words into the window.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    win_d  = win_q;
    pidx_d = pidx_q;
    pv_d   = '0;
    pv_d[0]   = (state_q == FETCH);
    pidx_d[0] = 4'(cnt_q);
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i]   = pv_q[i-1];
      pidx_d[i] = pidx_q[i-1];
    end
    if (pv_q[READ_LATENCY-1]) begin
      for (int s = 0; s < 9; s++)
        if (pidx_q[READ_LATENCY-1] == 4'(s)) win_d[s] = logic_data_r_in;
    end
  end

  // Flatten the upcoming window so the rule sees slot 8 on the cycle it arrives.
  always_comb begin
    win_flat = '0;
    for (int s = 0; s < 9; s++) win_flat[s*WORD_SIZE +: WORD_SIZE] = win_d[s];
  end

  assign next_word = life_rule(win_flat);

  // Sequencer: next state, cursor and registered output values.
  always_comb begin
    logic          last_word;
    logic [RW-1:0] row_n;
    logic [WW-1:0] word_n;
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    word_d   = word_q;
    addr_r_d = addr_r_q;
    addr_w_d = addr_w_q;
    data_w_d = data_w_q;
    wr_en_d  = 1'b0;
    swap_d   = 1'b0;
    last_word = (row_q == RW'(ROWS - 1)) && (word_q == WW'(WORDS_PER_ROW - 1));
    if (word_q == WW'(WORDS_PER_ROW - 1)) begin
      word_n = '0;
      row_n  = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    end else begin
      word_n = word_q + WW'(1);
      row_n  = row_q;
    end
    case (state_q)
      IDLE: if (start_in) begin
        state_d  = FETCH;
        cnt_d    = '0;
        row_d    = '0;
        word_d   = '0;
        addr_r_d = nbr_addr(0, 0, 0);
      end
      FETCH: if (cnt_q == CW'(8)) begin
        state_d = WAIT;
        cnt_d   = '0;
      end else begin
        cnt_d    = cnt_q + CW'(1);
        addr_r_d = nbr_addr(int'(row_q), int'(word_q), int'(cnt_q) + 1);
      end
      WAIT: if (cnt_q == CW'(READ_LATENCY - 1)) begin
        state_d  = WRITE;
        wr_en_d  = 1'b1;
        addr_w_d = LOG_MAX_ADDR'(int'(row_q) * WORDS_PER_ROW + int'(word_q));
        data_w_d = next_word;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      WRITE: begin
        row_d  = row_n;
        word_d = word_n;
        cnt_d  = '0;
        if (last_word) begin
          state_d = SWAP;
          swap_d  = 1'b1;
        end else begin
          state_d  = FETCH;
          addr_r_d = nbr_addr(int'(row_n), int'(word_n), 0);
        end
      end
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      word_q   <= '0;
      addr_r_q <= '0;
      addr_w_q <= '0;
      data_w_q <= '0;
      wr_en_q  <= 1'b0;
      swap_q   <= 1'b0;
      busy_q   <= 1'b0;
      pv_q     <= '0;
      // NOTE: the window is nine plain registers, so clearing them on reset is cheap and keeps restarts deterministic.
      for (int i = 0; i < READ_LATENCY; i++) pidx_q[i] <= '0;
      for (int s = 0; s < 9; s++) win_q[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      word_q   <= word_d;
      addr_r_q <= addr_r_d;
      addr_w_q <= addr_w_d;
      data_w_q <= data_w_d;
      wr_en_q  <= wr_en_d;
      swap_q   <= swap_d;
      busy_q   <= busy_d;
      pv_q     <= pv_d;
      pidx_q   <= pidx_d;
      win_q    <= win_d;
    end
  end

  assign logic_addr_r_out = addr_r_q;
  assign logic_addr_w_out = addr_w_q;
  assign logic_data_w_out = data_w_q;
  assign logic_wr_en_out  = wr_en_q;
  assign swap_out         = swap_q;
  assign busy_out         = busy_q;

endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: directed bench for life_engine on a 4x16 toroidal board.
// A cell-level reference model queues the expected writes for each generation;
// the writes the DUT produces are popped and compared as they appear.
module tb_life_engine;

  localparam int WS   = 8;
  localparam int LMA  = 11;
  localparam int NR   = 4;
  localparam int WPR  = 2;
  localparam int RL   = 2;
  localparam int NCOL = WS * WPR;

  typedef struct packed {
    logic [LMA-1:0] addr;
    logic [WS-1:0]  data;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start_in;
  logic [LMA-1:0] addr_r;
  logic [WS-1:0]  data_r;
  logic [LMA-1:0] addr_w;
  logic [WS-1:0]  data_w;
  logic           wr_en;
  logic           swap;
  logic           busy;

  logic [NCOL-1:0] cur_board [NR];
  logic [WS-1:0]   wbuf [NR*WPR];
  logic [WS-1:0]   rd_p1 = '0;
  logic [WS-1:0]   rd_p2 = '0;
  wr_t             exp_q [$];
  int              tests = 0;
  int              fails = 0;

  life_engine #(
    .WORD_SIZE(WS), .LOG_MAX_ADDR(LMA), .ROWS(NR),
    .WORDS_PER_ROW(WPR), .READ_LATENCY(RL)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_in),
    .logic_addr_r_out(addr_r), .logic_data_r_in(data_r),
    .logic_addr_w_out(addr_w), .logic_data_w_out(data_w),
    .logic_wr_en_out(wr_en), .swap_out(swap), .busy_out(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WS-1:0] mem_word(input logic [LMA-1:0] a);
    int ai;
    ai = int'(a);
    if (ai >= NR * WPR) return '0;
    return cur_board[ai / WPR][(ai % WPR) * WS +: WS];
  endfunction

  // Read port model: data appears two cycles after the address.
  always @(posedge clk) begin
    rd_p1 <= mem_word(addr_r);
    rd_p2 <= rd_p1;
  end
  assign data_r = rd_p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_board(input logic [NCOL-1:0] r0, r1, r2, r3);
    cur_board[0] = r0;
    cur_board[1] = r1;
    cur_board[2] = r2;
    cur_board[3] = r3;
  endtask

  // Reference generation computed cell by cell with modular neighbour indices.
  task automatic push_expected();
    logic [NCOL-1:0] nb [NR];
    wr_t e;
    int  n;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NCOL; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (!(dr == 0 && dc == 0))
              n += int'(cur_board[(r + dr + NR) % NR][(c + dc + NCOL) % NCOL]);
        nb[r][c] = (n == 3) || (cur_board[r][c] && n == 2);
      end
    end
    for (int a = 0; a < NR * WPR; a++) begin
      e.addr = LMA'(a);
      e.data = nb[a / WPR][(a % WPR) * WS +: WS];
      exp_q.push_back(e);
    end
  endtask

  // One generation, entered just after a negedge with the engine idle.
  task automatic run_gen(input int extra_a, input int extra_b, input int rst_at_write,
                         input bit start_in_swap);
    int busy_cycles = 0;
    int writes      = 0;
    int swaps       = 0;
    bit prev_wr     = 1'b0;
    bit done        = 1'b0;
    bit was_reset   = 1'b0;
    wr_t e;
    push_expected();
    for (int a = 0; a < NR * WPR; a++) wbuf[a] = '0;
    start_in = 1'b1;
    @(negedge clk);
    check("first_rd_addr", 32'(addr_r), 32'd7);
    check("busy_on_accept", 32'(busy), 32'd1);
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      if (cyc > 1) @(negedge clk);
      start_in = 1'b0;
      if (busy) busy_cycles++;
      if (wr_en) begin
        writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(addr_w), 32'(e.addr));
          check("wr_data", 32'(data_w), 32'(e.data));
        end
        if (int'(addr_w) < NR * WPR) wbuf[addr_w] = data_w;
        if (writes == rst_at_write) begin
          rst_n = 1'b0;
          #1;
          check("rst_outputs",
                {5'd0, addr_r, 5'd0, addr_w, data_w, 5'd0, wr_en, swap, busy}, 32'd0);
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_hold_quiet", {29'd0, wr_en, swap, busy}, 32'd0);
          end
          rst_n = 1'b1;
          @(negedge clk);
          check("after_release_idle", {29'd0, wr_en, swap, busy}, 32'd0);
          exp_q.delete();
          was_reset = 1'b1;
          done = 1'b1;
        end
      end
      if (!done && swap) begin
        swaps++;
        check("swap_after_last_write", 32'(prev_wr), 32'd1);
        if (start_in_swap) start_in = 1'b1;
      end
      if (!done && !busy) done = 1'b1;
      prev_wr = wr_en;
      if (!done && (cyc == extra_a || cyc == extra_b)) start_in = 1'b1;
    end
    check("gen_done", 32'(done), 32'd1);
    if (was_reset) begin
      check("rst_writes", 32'(writes), 32'(rst_at_write));
      check("rst_no_swap", 32'(swaps), 32'd0);
    end else begin
      check("busy_cycles", 32'(busy_cycles), 32'd97);
      check("write_count", 32'(writes), 32'd8);
      check("swap_count", 32'(swaps), 32'd1);
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      for (int a = 0; a < NR * WPR; a++) cur_board[a / WPR][(a % WPR) * WS +: WS] = wbuf[a];
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start_in = 1'b0;
    set_board('0, '0, '0, '0);

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_rd_addr", 32'(addr_r), 32'd0);
    check("reset_wr_addr", 32'(addr_w), 32'd0);
    check("reset_wr_data", 32'(data_w), 32'd0);
    check("reset_flags", {29'd0, wr_en, swap, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_flags", {29'd0, wr_en, swap, busy}, 32'd0);

    // Still life: the block must come back unchanged.
    set_board(16'h0000, 16'h0018, 16'h0018, 16'h0000);
    run_gen(0, 0, 0, 1'b0);
    check("block_r0", {wbuf[1], wbuf[0]}, 32'h0000);
    check("block_r1", {wbuf[3], wbuf[2]}, 32'h0018);
    check("block_r2", {wbuf[5], wbuf[4]}, 32'h0018);
    check("block_r3", {wbuf[7], wbuf[6]}, 32'h0000);

    // Blinker, with a start pulse during SWAP that must be ignored.
    set_board(16'h0000, 16'h001C, 16'h0000, 16'h0000);
    run_gen(0, 0, 0, 1'b1);
    check("blink_r0", {wbuf[1], wbuf[0]}, 32'h0008);
    check("blink_r1", {wbuf[3], wbuf[2]}, 32'h0008);
    check("blink_r2", {wbuf[5], wbuf[4]}, 32'h0008);
    check("blink_r3", {wbuf[7], wbuf[6]}, 32'h0000);
    @(negedge clk);
    check("swap_start_ignored", 32'(busy), 32'd0);

    // Wrap-around across the left board edge.
    set_board(16'h0001, 16'h0001, 16'h0001, 16'h0000);
    run_gen(0, 0, 0, 1'b0);
    check("wrap_r0", {wbuf[1], wbuf[0]}, 32'h0000);
    check("wrap_r1", {wbuf[3], wbuf[2]}, 32'h8003);
    check("wrap_r2", {wbuf[5], wbuf[4]}, 32'h0000);
    check("wrap_r3", {wbuf[7], wbuf[6]}, 32'h0000);

    // Start pulses while busy are dropped.
    set_board(16'h0000, 16'h001C, 16'h0000, 16'h0000);
    run_gen(5, 50, 0, 1'b0);

    // Reset during the third write, then a clean full generation.
    run_gen(0, 0, 3, 1'b0);
    run_gen(0, 0, 0, 1'b0);

    // Back-to-back: start in the idle cycle right after swap.
    run_gen(0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
